id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register with operand bypass and load-use hazard detection for the 5-stage pipelined CPU.
- Takes the combinational read data from the register file together with the decoded ID fields, and registers them into the EX stage.
- Resolves RAW hazards: bypasses write-back data at capture, forwards MEM/WB results into EX operands, and stalls ID one cycle on load-use.

Parameters:
XLEN, 32, datapath width
AW, 5, register index width
CTRLW, 16, width of opaque EX/MEM/WB control bundle

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous reset, active-low
id_valid  in  1  ID holds a real instruction
id_rs  in  AW  source 1 index (same value driven to register file SR1)
id_rt  in  AW  source 2 index (same value driven to register file SR2)
id_uses_rs  in  1  instruction reads rs
id_uses_rt  in  1  instruction reads rt
id_rd  in  AW  destination index
id_wreg  in  1  instruction writes rd
id_memread  in  1  instruction is a load
id_ctrl  in  CTRLW  remaining control bits, passed through
id_imm  in  XLEN  extended immediate
id_pc  in  XLEN  instruction PC
rf_rs_data  in  XLEN  register file SR1_OUT
rf_rt_data  in  XLEN  register file SR2_OUT
exm_wreg  in  1  MEM-stage instruction writes a register
exm_rd  in  AW  MEM-stage destination
exm_data  in  XLEN  MEM-stage ALU result
wb_wreg  in  1  WB write enable (same as register file WReg)
wb_rd  in  AW  WB destination (same as register file DR)
wb_data  in  XLEN  WB data (same as register file Data_in)
flush  in  1  taken-branch/jump redirect; kill the ID instruction
stall_id  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX instruction valid
ex_rs_val  out  XLEN  forwarded operand 1 (combinational)
ex_rt_val  out  XLEN  forwarded operand 2 (combinational)
ex_rs, ex_rt, ex_rd  out  AW  registered indices
ex_wreg, ex_memread  out  1  registered controls, forced 0 on bubble
ex_ctrl  out  CTRLW  registered control
ex_imm, ex_pc  out  XLEN  registered fields

Behaviour:
- Reset (rst_n=0, async): every register clears to 0, so ex_valid=ex_wreg=ex_memread=0 and all data outputs are 0. stall_id evaluates to 0.
- Latency: ID fields appear on the ex_* outputs one cycle after capture.
- Load-use stall (combinational): stall_id = id_valid & ex_valid & ex_memread & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- Register update per posedge, highest priority first:
  1. flush=1: insert a bubble (ex_valid, ex_wreg, ex_memread <= 0). Other fields are don't-care and are held.
  2. stall_id=1: insert a bubble. Upstream holds the ID instruction, which is re-evaluated next cycle.
  3. Otherwise: capture all id_* fields; ex_valid <= id_valid. ex_wreg and ex_memread are ANDed with id_valid.
- Capture-time WB bypass: the register file writes at the clock edge, so its read port shows stale data during the WB cycle.
  - Captured rs value = wb_data if wb_wreg & wb_rd!=0 & wb_rd==id_rs; else rf_rs_data.
  - The rt value is captured the same way.
- EX forwarding (combinational, applied per operand to the registered value):
  - Use exm_data if exm_wreg & exm_rd!=0 & exm_rd==ex_rs.
  - Else use wb_data if wb_wreg & wb_rd!=0 & wb_rd==ex_rs.
  - Else use the registered value.
  - MEM has priority over WB. Index 0 is never forwarded, so an $zero source always reads 0 via the register file.
- Loads: the one-cycle stall guarantees that a load result reaches EX only through the WB path, so exm forwarding needs no memread qualifier.
- Reset asserted mid-operation clears the pipeline slot immediately; no partial update survives.

Decomposition:
- Shared package: XLEN, AW, CTRLW, REG_ZERO=0.
- One sub-module, fwd_mux: index compare plus 3-way select, instantiated twice in EX and reused with the exm input tied off for the capture bypass.

Test Plan:
- Reset: hold rst_n=0 with id_valid=1 → ex_valid=0, ex_rs_val=0, stall_id=0. Release → first capture appears next cycle.
- MEM forward: ADD r3 in MEM with exm_data=0x55; EX has ex_rs=3 and registered value 0x11 → ex_rs_val=0x55. MEM and WB both target r3 (WB 0x66) → 0x55.
- WB capture bypass: wb writes r5=0xAB while ID reads rs=5 with rf_rs_data=0x00 → next cycle ex_rs_val=0xAB with no active forwards.
- Load-use: LW r7 in EX, ID uses rt=7 → stall_id=1 for exactly one cycle and a bubble enters EX. Next cycle stall_id=0; when the load reaches WB with wb_data=0x1234, ex_rt_val=0x1234.
- $zero: exm_wreg=1, exm_rd=0, exm_data=0xFF, ex_rs=0 → ex_rs_val=0. LW r0 followed by a use of r0 → no stall.
- Flush with stall: flush=1 while stall_id=1 → bubble; ex_valid=0 and ex_wreg=0 next cycle.

Source files
------------

// File: rtl/id_ex_operand_stage_pkg.sv
// Shared widths, types and constants for the ID/EX operand stage.
package id_ex_operand_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned CTRLW = 16;

  typedef logic [XLEN-1:0]  word_t;
  typedef logic [AW-1:0]    reg_idx_t;
  typedef logic [CTRLW-1:0] ctrl_t;

  localparam reg_idx_t REG_ZERO = '0;

  // Contents of the EX pipeline slot.
  typedef struct packed {
    logic     valid;
    logic     wreg;
    logic     memread;
    reg_idx_t rs;
    reg_idx_t rt;
    reg_idx_t rd;
    ctrl_t    ctrl;
    word_t    imm;
    word_t    pc;
    word_t    rs_val;
    word_t    rt_val;
  } ex_slot_t;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// ID-side inputs, bypass sources and EX-side outputs of the ID/EX operand stage.
interface id_ex_operand_stage_if;
  import id_ex_operand_stage_pkg::*;

  logic     id_valid;
  reg_idx_t id_rs;
  reg_idx_t id_rt;
  logic     id_uses_rs;
  logic     id_uses_rt;
  reg_idx_t id_rd;
  logic     id_wreg;
  logic     id_memread;
  ctrl_t    id_ctrl;
  word_t    id_imm;
  word_t    id_pc;
  word_t    rf_rs_data;
  word_t    rf_rt_data;
  logic     exm_wreg;
  reg_idx_t exm_rd;
  word_t    exm_data;
  logic     wb_wreg;
  reg_idx_t wb_rd;
  word_t    wb_data;
  logic     flush;

  logic     stall_id;
  logic     ex_valid;
  word_t    ex_rs_val;
  word_t    ex_rt_val;
  reg_idx_t ex_rs;
  reg_idx_t ex_rt;
  reg_idx_t ex_rd;
  logic     ex_wreg;
  logic     ex_memread;
  ctrl_t    ex_ctrl;
  word_t    ex_imm;
  word_t    ex_pc;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_wreg, id_memread,
           id_ctrl, id_imm, id_pc, rf_rs_data, rf_rt_data, exm_wreg, exm_rd, exm_data,
           wb_wreg, wb_rd, wb_data, flush,
    input  stall_id, ex_valid, ex_rs_val, ex_rt_val, ex_rs, ex_rt, ex_rd, ex_wreg,
           ex_memread, ex_ctrl, ex_imm, ex_pc
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_wreg, id_memread,
           id_ctrl, id_imm, id_pc, rf_rs_data, rf_rt_data, exm_wreg, exm_rd, exm_data,
           wb_wreg, wb_rd, wb_data, flush,
    output stall_id, ex_valid, ex_rs_val, ex_rt_val, ex_rs, ex_rt, ex_rd, ex_wreg,
           ex_memread, ex_ctrl, ex_imm, ex_pc
  );

endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Operand select: MEM result, then WB result, then the base value; $zero never matches.
module id_ex_operand_stage_fwd_mux
  import id_ex_operand_stage_pkg::*;
(
  input  reg_idx_t src_i,
  input  word_t    base_i,
  input  logic     exm_wreg_i,
  input  reg_idx_t exm_rd_i,
  input  word_t    exm_data_i,
  input  logic     wb_wreg_i,
  input  reg_idx_t wb_rd_i,
  input  word_t    wb_data_i,
  output word_t    val_o
);

  logic exm_hit;
  logic wb_hit;

  always_comb begin
    exm_hit = exm_wreg_i && (exm_rd_i != REG_ZERO) && (exm_rd_i == src_i);
    wb_hit  = wb_wreg_i  && (wb_rd_i  != REG_ZERO) && (wb_rd_i  == src_i);
    if (exm_hit) begin
      val_o = exm_data_i;
    end else if (wb_hit) begin
      val_o = wb_data_i;
    end else begin
      val_o = base_i;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with WB capture bypass, MEM/WB forwarding into EX and
// load-use stall detection.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  id_ex_operand_stage_if.slave bus_io
);

  ex_slot_t slot_q, slot_d;
  word_t    cap_rs_val, cap_rt_val;
  word_t    fwd_rs_val, fwd_rt_val;
  logic     stall;

  // The register file writes at the edge, so its read port is stale for the WB register.
  id_ex_operand_stage_fwd_mux u_cap_rs (
    .src_i      (bus_io.id_rs),
    .base_i     (bus_io.rf_rs_data),
    .exm_wreg_i (1'b0),
    .exm_rd_i   (REG_ZERO),
    .exm_data_i ('0),
    .wb_wreg_i  (bus_io.wb_wreg),
    .wb_rd_i    (bus_io.wb_rd),
    .wb_data_i  (bus_io.wb_data),
    .val_o      (cap_rs_val)
  );

  id_ex_operand_stage_fwd_mux u_cap_rt (
    .src_i      (bus_io.id_rt),
    .base_i     (bus_io.rf_rt_data),
    .exm_wreg_i (1'b0),
    .exm_rd_i   (REG_ZERO),
    .exm_data_i ('0),
    .wb_wreg_i  (bus_io.wb_wreg),
    .wb_rd_i    (bus_io.wb_rd),
    .wb_data_i  (bus_io.wb_data),
    .val_o      (cap_rt_val)
  );

  id_ex_operand_stage_fwd_mux u_ex_rs (
    .src_i      (slot_q.rs),
    .base_i     (slot_q.rs_val),
    .exm_wreg_i (bus_io.exm_wreg),
    .exm_rd_i   (bus_io.exm_rd),
    .exm_data_i (bus_io.exm_data),
    .wb_wreg_i  (bus_io.wb_wreg),
    .wb_rd_i    (bus_io.wb_rd),
    .wb_data_i  (bus_io.wb_data),
    .val_o      (fwd_rs_val)
  );

  id_ex_operand_stage_fwd_mux u_ex_rt (
    .src_i      (slot_q.rt),
    .base_i     (slot_q.rt_val),
    .exm_wreg_i (bus_io.exm_wreg),
    .exm_rd_i   (bus_io.exm_rd),
    .exm_data_i (bus_io.exm_data),
    .wb_wreg_i  (bus_io.wb_wreg),
    .wb_rd_i    (bus_io.wb_rd),
    .wb_data_i  (bus_io.wb_data),
    .val_o      (fwd_rt_val)
  );

  always_comb begin
    stall = bus_io.id_valid && slot_q.valid && slot_q.memread && (slot_q.rd != REG_ZERO) &&
            ((bus_io.id_uses_rs && (bus_io.id_rs == slot_q.rd)) ||
             (bus_io.id_uses_rt && (bus_io.id_rt == slot_q.rd)));
  end

  always_comb begin
    slot_d = slot_q;
    if (bus_io.flush || stall) begin
      // Bubble: data fields are held, only the qualifiers drop.
      slot_d.valid   = 1'b0;
      slot_d.wreg    = 1'b0;
      slot_d.memread = 1'b0;
    end else begin
      slot_d.valid   = bus_io.id_valid;
      slot_d.wreg    = bus_io.id_wreg && bus_io.id_valid;
      slot_d.memread = bus_io.id_memread && bus_io.id_valid;
      slot_d.rs      = bus_io.id_rs;
      slot_d.rt      = bus_io.id_rt;
      slot_d.rd      = bus_io.id_rd;
      slot_d.ctrl    = bus_io.id_ctrl;
      slot_d.imm     = bus_io.id_imm;
      slot_d.pc      = bus_io.id_pc;
      slot_d.rs_val  = cap_rs_val;
      slot_d.rt_val  = cap_rt_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign bus_io.stall_id   = stall;
  assign bus_io.ex_valid   = slot_q.valid;
  assign bus_io.ex_rs_val  = fwd_rs_val;
  assign bus_io.ex_rt_val  = fwd_rt_val;
  assign bus_io.ex_rs      = slot_q.rs;
  assign bus_io.ex_rt      = slot_q.rt;
  assign bus_io.ex_rd      = slot_q.rd;
  assign bus_io.ex_wreg    = slot_q.wreg;
  assign bus_io.ex_memread = slot_q.memread;
  assign bus_io.ex_ctrl    = slot_q.ctrl;
  assign bus_io.ex_imm     = slot_q.imm;
  assign bus_io.ex_pc      = slot_q.pc;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Random instruction stream through a modelled pipeline; EX operands are checked against
// architectural register values in program order.
module tb_id_ex_operand_stage;
  import id_ex_operand_stage_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        uses_rs;
    logic        uses_rt;
    logic        wreg;
    logic        memread;
    logic [15:0] ctrl;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] result;
  } instr_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [15:0] ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        uses_rs;
    logic        uses_rt;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_operand_stage_if bus ();

  id_ex_operand_stage u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic mon_en = 1'b0;
  logic exp_stall = 1'b0;
  logic exp_valid = 1'b0;
  logic exp_wreg = 1'b0;
  logic exp_memread = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic instr_t rand_instr(input logic allow_valid);
    instr_t i;
    i.valid   = allow_valid && ($urandom_range(0, 99) < 85);
    i.rs      = 5'($urandom_range(0, 7));
    i.rt      = 5'($urandom_range(0, 7));
    i.rd      = 5'($urandom_range(0, 7));
    i.uses_rs = ($urandom_range(0, 3) != 0);
    i.uses_rt = ($urandom_range(0, 3) != 0);
    i.memread = ($urandom_range(0, 3) == 0);
    i.wreg    = i.memread || ($urandom_range(0, 4) != 0);
    i.ctrl    = 16'($urandom);
    i.imm     = $urandom;
    i.pc      = $urandom;
    i.result  = $urandom;
    return i;
  endfunction

  function automatic instr_t bubble();
    instr_t b;
    b = rand_instr(1'b0);
    b.wreg    = 1'b0;
    b.memread = 1'b0;
    return b;
  endfunction

  // Monitor: per-cycle qualifiers, and a scoreboard pop for every valid EX instruction.
  always @(negedge clk) begin
    if (mon_en) begin
      check("stall_id", 32'(bus.stall_id), 32'(exp_stall));
      check("ex_valid", 32'(bus.ex_valid), 32'(exp_valid));
      check("ex_wreg", 32'(bus.ex_wreg), 32'(exp_wreg));
      check("ex_memread", 32'(bus.ex_memread), 32'(exp_memread));
      if (bus.ex_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL ex_unexpected: got ex_pc 0x%08h, expected no valid instruction",
                   bus.ex_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("ex_pc", bus.ex_pc, mon_e.pc);
          check("ex_imm", bus.ex_imm, mon_e.imm);
          check("ex_ctrl", 32'(bus.ex_ctrl), 32'(mon_e.ctrl));
          check("ex_rs", 32'(bus.ex_rs), 32'(mon_e.rs));
          check("ex_rt", 32'(bus.ex_rt), 32'(mon_e.rt));
          check("ex_rd", 32'(bus.ex_rd), 32'(mon_e.rd));
          if (mon_e.uses_rs) check("ex_rs_val", bus.ex_rs_val, mon_e.rs_val);
          if (mon_e.uses_rt) check("ex_rt_val", bus.ex_rt_val, mon_e.rt_val);
        end
      end
    end
  end

  task automatic drive_id(input instr_t i);
    bus.id_valid   = i.valid;
    bus.id_rs      = i.rs;
    bus.id_rt      = i.rt;
    bus.id_uses_rs = i.uses_rs;
    bus.id_uses_rt = i.uses_rt;
    bus.id_rd      = i.rd;
    bus.id_wreg    = i.wreg;
    bus.id_memread = i.memread;
    bus.id_ctrl    = i.ctrl;
    bus.id_imm     = i.imm;
    bus.id_pc      = i.pc;
  endtask

  initial begin
    instr_t      id_cur, ex_m, mem_m, wb_m, tmp;
    exp_t        e_new;
    logic [31:0] rf_m [32];
    logic [31:0] arch [32];
    logic        hold_id, flush_v, cap, quiet;
    logic [31:0] pc_ctr;

    for (int r = 0; r < 32; r++) begin
      rf_m[r] = '0;
      arch[r] = '0;
    end

    // Reset with a live instruction presented at ID.
    tmp = rand_instr(1'b1);
    tmp.valid = 1'b1;
    drive_id(tmp);
    bus.rf_rs_data = 32'h1111_1111;
    bus.rf_rt_data = 32'h2222_2222;
    bus.exm_wreg = 1'b0;
    bus.exm_rd   = '0;
    bus.exm_data = '0;
    bus.wb_wreg  = 1'b0;
    bus.wb_rd    = '0;
    bus.wb_data  = '0;
    bus.flush    = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset ex_valid", 32'(bus.ex_valid), 32'd0);
    check("reset ex_rs_val", bus.ex_rs_val, 32'd0);
    check("reset ex_rt_val", bus.ex_rt_val, 32'd0);
    check("reset stall_id", 32'(bus.stall_id), 32'd0);
    check("reset ex_wreg", 32'(bus.ex_wreg), 32'd0);
    check("reset ex_memread", 32'(bus.ex_memread), 32'd0);
    check("reset ex_pc", bus.ex_pc, 32'd0);
    check("reset ex_imm", bus.ex_imm, 32'd0);

    @(negedge clk);
    rst_n   = 1'b1;
    ex_m    = bubble();
    mem_m   = bubble();
    wb_m    = bubble();
    hold_id = 1'b0;
    pc_ctr  = 32'h0000_1000;

    for (int cyc = 0; cyc < 3006; cyc++) begin
      quiet = (cyc >= 3000);
      if (!hold_id) begin
        id_cur    = rand_instr(!quiet);
        id_cur.pc = pc_ctr;
        pc_ctr    = pc_ctr + 32'd4;
      end
      flush_v = !quiet && ($urandom_range(0, 9) == 0);

      drive_id(id_cur);
      bus.rf_rs_data = rf_m[id_cur.rs];
      bus.rf_rt_data = rf_m[id_cur.rt];
      bus.exm_wreg   = mem_m.wreg;
      bus.exm_rd     = mem_m.rd;
      // A load in MEM has only its address on the ALU path, never the loaded value.
      bus.exm_data   = mem_m.memread ? $urandom : mem_m.result;
      bus.wb_wreg    = wb_m.wreg;
      bus.wb_rd      = wb_m.rd;
      bus.wb_data    = wb_m.result;
      bus.flush      = flush_v;

      exp_stall = id_cur.valid && ex_m.valid && ex_m.memread && (ex_m.rd != 5'd0) &&
                  ((id_cur.uses_rs && (id_cur.rs == ex_m.rd)) ||
                   (id_cur.uses_rt && (id_cur.rt == ex_m.rd)));
      cap = !flush_v && !exp_stall;
      if (cap && id_cur.valid) begin
        e_new.pc      = id_cur.pc;
        e_new.imm     = id_cur.imm;
        e_new.ctrl    = id_cur.ctrl;
        e_new.rs      = id_cur.rs;
        e_new.rt      = id_cur.rt;
        e_new.rd      = id_cur.rd;
        e_new.uses_rs = id_cur.uses_rs;
        e_new.uses_rt = id_cur.uses_rt;
        e_new.rs_val  = arch[id_cur.rs];
        e_new.rt_val  = arch[id_cur.rt];
        exp_q.push_back(e_new);
        if (id_cur.wreg && (id_cur.rd != 5'd0)) arch[id_cur.rd] = id_cur.result;
      end
      hold_id = exp_stall && !flush_v;

      @(posedge clk);
      #1;
      if (wb_m.wreg && (wb_m.rd != 5'd0)) rf_m[wb_m.rd] = wb_m.result;
      wb_m  = mem_m;
      mem_m = ex_m;
      if (cap) begin
        ex_m         = id_cur;
        ex_m.wreg    = id_cur.wreg && id_cur.valid;
        ex_m.memread = id_cur.memread && id_cur.valid;
      end else begin
        ex_m = bubble();
      end
      exp_valid   = ex_m.valid;
      exp_wreg    = ex_m.wreg;
      exp_memread = ex_m.memread;
      mon_en      = 1'b1;
    end

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("drain queue empty", 32'(exp_q.size()), 32'd0);

    // Capture one known instruction, then pull reset mid-cycle.
    tmp = rand_instr(1'b1);
    tmp.valid   = 1'b1;
    tmp.wreg    = 1'b1;
    tmp.memread = 1'b0;
    tmp.pc      = 32'hDEAD_BEEF;
    drive_id(tmp);
    bus.flush   = 1'b0;
    bus.exm_wreg = 1'b0;
    bus.wb_wreg  = 1'b0;
    @(posedge clk);
    #2;
    check("pre-reset ex_valid", 32'(bus.ex_valid), 32'd1);
    check("pre-reset ex_pc", bus.ex_pc, 32'hDEAD_BEEF);
    check("pre-reset ex_wreg", 32'(bus.ex_wreg), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset ex_valid", 32'(bus.ex_valid), 32'd0);
    check("async reset ex_pc", bus.ex_pc, 32'd0);
    check("async reset ex_wreg", 32'(bus.ex_wreg), 32'd0);
    check("async reset ex_imm", bus.ex_imm, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
